bit_assembler: RTL and testbench

//   Serial-to-parallel stage downstream of the 1-bit save/value memory cell.
//   - Captures one bit per clock whenever save=1 and packs WIDTH bits into a word.
//   - Presents each finished word on a valid/ready output register.
//   - Reports partial-word fill and a sticky overflow flag for bits dropped while stalled.

---
 rtl/bit_assembler_pkg.sv | 10 +
 rtl/bit_assembler_if.sv | 24 ++
 rtl/bit_assembler_word_out_reg.sv | 32 +++
 rtl/bit_assembler.sv | 96 +++++++++
 tb/tb_bit_assembler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bit_assembler_pkg.sv
// Helpers shared by serial-to-parallel stages: maps a running bit count to
// the word slot it lands in.
package bit_assembler_pkg;

  function automatic int unsigned slot_index(int unsigned fill, int unsigned width,
                                             bit msb_first);
    return msb_first ? (width - 1 - fill) : fill;
  endfunction

endpackage

// File: rtl/bit_assembler_if.sv
// Serial capture inputs plus the assembled-word valid/ready output and status.
interface bit_assembler_if #(parameter int WIDTH = 8);
  localparam int FW = $clog2(WIDTH + 1);

  logic             save;
  logic             value;
  logic             flush;
  logic             clr_overflow;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    fill;
  logic             overflow;

  modport master (
    output save, value, flush, out_ready, clr_overflow,
    input  out_data, out_valid, fill, overflow
  );

  modport slave (
    input  save, value, flush, out_ready, clr_overflow,
    output out_data, out_valid, fill, overflow
  );
endinterface

// File: rtl/bit_assembler_word_out_reg.sv
// Word output register with valid flag; the owner only asserts load_i while
// free_o is high, so an unaccepted word is never overwritten.
module word_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             free_o
);
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) data_q <= data_i;
      if (load_i)       valid_q <= 1'b1;
      else if (ready_i) valid_q <= 1'b0;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/bit_assembler.sv
// Packs one serial bit per save strobe into WIDTH-bit words; a full or flushed
// word waits in HOLD while the output register is occupied.
module bit_assembler
  import bit_assembler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           reset,
  bit_assembler_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_bit, word;
  logic [FW-1:0]    fill_q, fill_d, cnt_n;
  logic             ovf_q, ovf_d;
  logic             load, free, drop, close;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      acc_q   <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  // Unfilled slots are always zero, so OR-ing in the new bit is enough and
  // gives zero padding on flush for free.
  assign acc_bit = acc_q | (WIDTH'(bus.value) << slot_index(32'(fill_q), WIDTH, MSB_FIRST));
  assign cnt_n   = bus.save ? fill_q + FW'(1) : fill_q;
  assign close   = (bus.save && fill_q == LAST) || (bus.flush && cnt_n != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close && !free) state_d = HOLD;
      HOLD:    if (free)           state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    word   = acc_q;
    load   = 1'b0;
    drop   = 1'b0;
    case (state_q)
      FILL: begin
        word   = bus.save ? acc_bit : acc_q;
        acc_d  = word;
        fill_d = cnt_n;
        if (close && free) begin
          load   = 1'b1;
          acc_d  = '0;
          fill_d = '0;
        end
      end
      HOLD: begin
        drop = bus.save;
        if (free) begin
          load   = 1'b1;
          acc_d  = '0;
          fill_d = '0;
        end
      end
      default: ;
    endcase
    ovf_d = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : ovf_q);
  end

  word_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .data_i  (word),
    .ready_i (bus.out_ready),
    .data_o  (bus.out_data),
    .valid_o (bus.out_valid),
    .free_o  (free)
  );

  assign bus.fill     = fill_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bit_assembler.sv
// Directed bench for bit_assembler: LSB-first and MSB-first instances, words
// checked by a queue-based scoreboard on every output handshake.
module tb_bit_assembler;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_assembler_if #(.WIDTH(W)) ifa ();
  bit_assembler_if #(.WIDTH(W)) ifb ();

  bit_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  bit_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word_a: got %0h expected no word", ifa.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_a.pop_front();
        check("word_a", 32'(ifa.out_data), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word_b: got %0h expected no word", ifb.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_b.pop_front();
        check("word_b", 32'(ifb.out_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] bits;
    reset = 1'b1;
    ifa.save = 1'b0; ifa.value = 1'b0; ifa.flush = 1'b0; ifa.clr_overflow = 1'b0; ifa.out_ready = 1'b0;
    ifb.save = 1'b0; ifb.value = 1'b0; ifb.flush = 1'b0; ifb.clr_overflow = 1'b0; ifb.out_ready = 1'b0;

    // 1: reset with save toggling
    for (int i = 0; i < 2; i++) begin
      ifa.save = ~ifa.save; ifa.value = 1'b1;
      tick();
    end
    check("rst_valid", 32'(ifa.out_valid), 0);
    check("rst_fill", 32'(ifa.fill), 0);
    check("rst_ovf", 32'(ifa.overflow), 0);
    check("rst_data", 32'(ifa.out_data), 0);
    reset = 1'b0; ifa.save = 1'b0; ifa.value = 1'b0;
    tick();
    check("rst_fill_after", 32'(ifa.fill), 0);

    // 2: basic LSB-first word
    ifa.out_ready = 1'b1;
    bits = 8'h8D;
    exp_a.push_back(8'h8D);
    for (int i = 0; i < 8; i++) begin
      ifa.save = 1'b1; ifa.value = bits[i];
      tick();
      if (i == 6) check("t2_valid_early", 32'(ifa.out_valid), 0);
    end
    check("t2_valid", 32'(ifa.out_valid), 1);
    ifa.save = 1'b0;
    tick();
    check("t2_pulse", 32'(ifa.out_valid), 0);
    check("t2_fill", 32'(ifa.fill), 0);

    // 3: same stream MSB-first
    ifb.out_ready = 1'b1;
    exp_b.push_back(8'hB1);
    for (int i = 0; i < 8; i++) begin
      ifb.save = 1'b1; ifb.value = bits[i];
      tick();
    end
    check("t3_valid", 32'(ifb.out_valid), 1);
    check("t3_data", 32'(ifb.out_data), 32'h B1);
    ifb.save = 1'b0;
    tick();
    check("t3_pulse", 32'(ifb.out_valid), 0);

    // 4: flush partial word, then flush with nothing held
    exp_a.push_back(8'h07);
    for (int i = 0; i < 3; i++) begin
      ifa.save = 1'b1; ifa.value = 1'b1;
      tick();
    end
    check("t4_fill3", 32'(ifa.fill), 3);
    ifa.save = 1'b0; ifa.flush = 1'b1;
    tick();
    check("t4_valid", 32'(ifa.out_valid), 1);
    check("t4_data", 32'(ifa.out_data), 32'h07);
    check("t4_fill0", 32'(ifa.fill), 0);
    tick();
    check("t4_empty_flush", 32'(ifa.out_valid), 0);
    ifa.flush = 1'b0;

    // 5: stall, hold, overflow, release
    ifa.out_ready = 1'b0;
    exp_a.push_back(8'hFF);
    exp_a.push_back(8'h0F);
    for (int i = 0; i < 8; i++) begin
      ifa.save = 1'b1; ifa.value = 1'b1;
      tick();
    end
    check("t5_valid1", 32'(ifa.out_valid), 1);
    bits = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      ifa.save = 1'b1; ifa.value = bits[i];
      tick();
    end
    check("t5_hold_fill", 32'(ifa.fill), 8);
    check("t5_hold_data", 32'(ifa.out_data), 32'hFF);
    check("t5_no_ovf_yet", 32'(ifa.overflow), 0);
    ifa.save = 1'b1; ifa.value = 1'b1;
    tick();
    check("t5_ovf", 32'(ifa.overflow), 1);
    check("t5_fill_cap", 32'(ifa.fill), 8);
    check("t5_stable", 32'(ifa.out_data), 32'hFF);
    ifa.save = 1'b0; ifa.flush = 1'b1;
    tick();
    check("t5_flush_ign", 32'(ifa.fill), 8);
    ifa.flush = 1'b0; ifa.out_ready = 1'b1;
    tick();
    check("t5_b2b_valid", 32'(ifa.out_valid), 1);
    check("t5_b2b_data", 32'(ifa.out_data), 32'h0F);
    check("t5_fill_rel", 32'(ifa.fill), 0);
    tick();
    check("t5_drain", 32'(ifa.out_valid), 0);
    check("t5_sticky", 32'(ifa.overflow), 1);
    ifa.clr_overflow = 1'b1;
    tick();
    check("t5_clr", 32'(ifa.overflow), 0);
    ifa.clr_overflow = 1'b0;

    // 6: continuous words, then reset mid-word
    exp_a.push_back(8'h5A);
    exp_a.push_back(8'hC3);
    for (int i = 0; i < 16; i++) begin
      bits = (i < 8) ? 8'h5A : 8'hC3;
      ifa.save = 1'b1; ifa.value = bits[i % 8];
      tick();
      if (i == 7 || i == 15) check("t6_word_valid", 32'(ifa.out_valid), 1);
      if (i == 8) check("t6_gap", 32'(ifa.out_valid), 0);
    end
    for (int i = 0; i < 5; i++) begin
      ifa.save = 1'b1; ifa.value = 1'b1;
      tick();
    end
    check("t6_fill5", 32'(ifa.fill), 5);
    reset = 1'b1;
    tick();
    check("t6_rst_fill", 32'(ifa.fill), 0);
    check("t6_rst_valid", 32'(ifa.out_valid), 0);
    reset = 1'b0;
    exp_a.push_back(8'h3C);
    bits = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      ifa.save = 1'b1; ifa.value = bits[i];
      tick();
    end
    check("t6_fresh_data", 32'(ifa.out_data), 32'h3C);
    ifa.save = 1'b0;
    tick();
    tick();

    check("qa_empty", 32'(exp_a.size()), 0);
    check("qb_empty", 32'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
